// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst-bounded arbiter sharing one FIFO write port among N producers
module fifo_wr_arbiter #(
    parameter int N      = 4,
    parameter int DWIDTH = 8,
    parameter int BURST  = 4
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [N-1:0]          req_valid_i,
    input  logic [N*DWIDTH-1:0]   req_data_i,
    output logic [N-1:0]          req_ready_o,
    input  logic                  fifo_full_i,
    output logic                  fifo_wrreq_o,
    output logic [DWIDTH-1:0]     fifo_data_o,
    output logic [N-1:0]          grant_o,
    output logic                  busy_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {
        ST_ARB,
        ST_GRANT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   sel_idx;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   gnt_inc;
    logic            sel_found;
    logic            granted;
    logic            wr;
    logic            release_now;
    logic [N-1:0]    gnt_onehot;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr_q) + i) % N);
            if (req_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign gnt_inc    = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + 1'b1;
    assign granted    = (state_q == ST_GRANT);
    assign gnt_onehot = N'(1) << gnt_q;

    // Outputs are gated by srst_i so nothing is written in the reset cycle itself.
    assign wr          = granted && !srst_i && req_valid_i[gnt_q] && !fifo_full_i;
    assign release_now = !req_valid_i[gnt_q] || (wr && (cnt_q == CW'(BURST - 1)));

    assign busy_o       = granted;
    assign grant_o      = granted ? gnt_onehot : '0;
    assign fifo_wrreq_o = wr;
    assign req_ready_o  = wr ? gnt_onehot : '0;
    assign fifo_data_o  = (granted && !srst_i) ? req_data_i[gnt_q*DWIDTH +: DWIDTH] : '0;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ARB: begin
                if (sel_found) begin
                    state_d = ST_GRANT;
                    gnt_d   = sel_idx;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_d = ST_ARB;
                    ptr_d   = gnt_inc;
                end else if (wr) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= ST_ARB;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter with directed and random traffic
module tb_fifo_wr_arbiter;

    localparam int N      = 4;
    localparam int DWIDTH = 8;
    localparam int BURST  = 4;

    logic              clk = 1'b0;
    logic              srst;
    logic [N-1:0]      valid;
    logic [N*DWIDTH-1:0] rdata;
    logic              full;
    logic [N-1:0]      ready;
    logic              wrreq;
    logic [DWIDTH-1:0] fdata;
    logic [N-1:0]      grant;
    logic              busy;

    fifo_wr_arbiter #(.N(N), .DWIDTH(DWIDTH), .BURST(BURST)) dut (
        .clk_i        (clk),
        .srst_i       (srst),
        .req_valid_i  (valid),
        .req_data_i   (rdata),
        .req_ready_o  (ready),
        .fifo_full_i  (full),
        .fifo_wrreq_o (wrreq),
        .fifo_data_o  (fdata),
        .grant_o      (grant),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the port, where the rotation resumes, words taken this grant.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_taken = 0;
    int seq [N];
    int left [N];

    logic              e_busy  = 1'b0;
    logic              e_wr    = 1'b0;
    logic [N-1:0]      e_grant = '0;
    logic [N-1:0]      e_ready = '0;
    logic [DWIDTH-1:0] e_data  = '0;

    logic [DWIDTH-1:0] sb [$];
    int                gseq [$];
    int                wr_cnt = 0;
    int                n_pass = 0;
    int                n_total = 0;
    logic [N-1:0]      prev_grant = '0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endfunction

    task automatic cycle(input logic [N-1:0] want, input logic f, input logic r);
        logic [N-1:0] v;
        bit           found;
        for (int k = 0; k < N; k++) begin
            v[k] = want[k] && (left[k] > 0);
            rdata[k*DWIDTH +: DWIDTH] = DWIDTH'(k * 16 + seq[k] % 16);
        end
        valid = v;
        full  = f;
        srst  = r;
        e_busy  = (m_owner >= 0);
        e_grant = e_busy ? N'(1 << m_owner) : '0;
        e_wr    = !r && e_busy && v[m_owner] && !f;
        e_ready = e_wr ? e_grant : '0;
        e_data  = (e_busy && !r) ? DWIDTH'(m_owner * 16 + seq[m_owner] % 16) : '0;
        if (e_wr) sb.push_back(e_data);
        @(posedge clk);
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_taken = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!found && v[(m_ptr + i) % N]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + i) % N;
                    m_taken = 0;
                end
            end
        end else begin
            if (e_wr) begin
                seq[m_owner]++;
                left[m_owner]--;
                m_taken++;
            end
            if (!v[m_owner] || m_taken == BURST) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        chk("grant", 32'(grant), 32'(e_grant));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("wrreq", 32'(wrreq), 32'(e_wr));
        chk("ready", 32'(ready), 32'(e_ready));
        chk("data", 32'(fdata), 32'(e_data));
        chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
        if (wrreq) begin
            wr_cnt++;
            chk("write_while_full", 32'(full), 32'd0);
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("sb_data", 32'(fdata), 32'(sb.pop_front()));
        end
        if (grant != '0 && prev_grant == '0) begin
            for (int k = 0; k < N; k++) if (grant[k]) gseq.push_back(k);
        end
        prev_grant = grant;
    end

    task automatic chk_gseq(input string name, input int exp [$]);
        chk({name, "_count"}, 32'(gseq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < gseq.size()) chk(name, 32'(gseq[i]), 32'(exp[i]));
        end
    endtask

    int base;
    int exp_q [$];

    initial begin
        for (int k = 0; k < N; k++) begin
            seq[k]  = 0;
            left[k] = 1000;
        end
        valid = '0;
        rdata = '0;
        full  = 1'b0;
        srst  = 1'b1;

        repeat (2) cycle('0, 1'b0, 1'b1);

        // Round robin with all requesters always valid.
        gseq.delete();
        base = wr_cnt;
        repeat (21) cycle(4'hF, 1'b0, 1'b0);
        chk("rr_writes_20cyc", 32'(wr_cnt - base), 32'd16);
        cycle(4'hF, 1'b0, 1'b0);
        exp_q = '{0, 1, 2, 3, 0};
        chk_gseq("rr_order", exp_q);
        repeat (3) cycle('0, 1'b0, 1'b0);

        // Reset mid-burst while requester 1 holds the grant.
        repeat (3) cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b1);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        gseq.delete();
        repeat (2) cycle(4'hF, 1'b0, 1'b0);
        exp_q = '{0};
        chk_gseq("post_rst_first", exp_q);
        repeat (2) cycle('0, 1'b0, 1'b0);

        // Full back-pressure on requester 2.
        base = wr_cnt;
        repeat (3) cycle(4'b0100, 1'b0, 1'b0);
        repeat (3) begin
            cycle(4'b0100, 1'b1, 1'b0);
            chk("bp_grant_held", 32'(grant), 32'h4);
        end
        repeat (2) cycle(4'b0100, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        chk("bp_writes", 32'(wr_cnt - base), 32'd4);
        chk("bp_released", 32'(busy), 32'd0);

        // Early release by requester 0, rotation skips idle 1 and 2.
        cycle('0, 1'b0, 1'b1);
        gseq.delete();
        base = wr_cnt;
        repeat (3) cycle(4'b1001, 1'b0, 1'b0);
        repeat (6) cycle(4'b1000, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        chk("early_writes", 32'(wr_cnt - base), 32'd6);
        exp_q = '{0, 3};
        chk_gseq("early_order", exp_q);

        // Single requester with 10 words wraps the pointer each time.
        left[3] = 10;
        gseq.delete();
        base = wr_cnt;
        repeat (16) cycle(4'b1000, 1'b0, 1'b0);
        chk("wrap_writes", 32'(wr_cnt - base), 32'd10);
        exp_q = '{3, 3, 3};
        chk_gseq("wrap_grants", exp_q);
        left[3] = 1000;

        // Random traffic with 30% full and rare resets.
        repeat (600) begin
            logic [N-1:0] w;
            for (int k = 0; k < N; k++) w[k] = ($urandom_range(0, 99) < 60);
            cycle(w, $urandom_range(0, 99) < 30, $urandom_range(0, 199) == 0);
        end
        repeat (4) cycle('0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one single-clock FIFO (clock/data/wrreq/full interface) between N independent producers.
- Each producer uses a valid/ready handshake.
- The arbiter grants one producer at a time and holds the grant for a bounded burst.
- It drives the FIFO's wrreq/data and never writes while the FIFO reports full.
- Sits directly in front of the FIFO write port. The FIFO read side is untouched.

Parameters:
N, 4, number of requesters (2..8)
DWIDTH, 8, data word width, equal to the FIFO data width
BURST, 4, max words accepted per grant before forced rotation (1..16)

Ports:
clk_i  input  1  clock, all logic on rising edge
srst_i  input  1  synchronous active-high reset
req_valid_i  input  N  per-requester word valid
req_data_i  input  N*DWIDTH  per-requester data, requester k at bits [k*DWIDTH +: DWIDTH]
req_ready_o  output  N  per-requester accept; transfer when valid&ready
fifo_full_i  input  1  FIFO full flag
fifo_wrreq_o  output  1  FIFO write request
fifo_data_o  output  DWIDTH  FIFO write data
grant_o  output  N  one-hot current grant, all-zero when not granted
busy_o  output  1  1 while in GRANT state

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high: srst_i sampled high at a rising edge clears all state at that edge.
  - Reset values: state=ARB, grant_o=0, busy_o=0, rr pointer=0, burst count=0.
  - Combinational outputs during and after reset: fifo_wrreq_o=0, req_ready_o=0, fifo_data_o=0.
  - Reset asserted mid-burst drops the grant at that edge. No partial state survives.
- State machine, two registered states:
  - ARB:
    - grant_o=0, busy_o=0, all ready=0.
    - If any req_valid_i bit is set, select the first set bit scanning ptr, ptr+1, ... (mod N).
    - Next edge: grant_o=onehot(sel), burst count=0, state=GRANT.
    - If none are valid, stay in ARB.
  - GRANT with index g:
    - busy_o=1.
    - wr = req_valid_i[g] & ~fifo_full_i (combinational).
    - fifo_wrreq_o=wr, req_ready_o[g]=wr, all other ready=0.
    - fifo_data_o = req_data_i slice g while granted, 0 otherwise.
- Release, evaluated each GRANT cycle:
  - (a) wr=1 and burst count==BURST-1: this word is written, then release.
  - (b) req_valid_i[g]=0: no write this cycle, release.
  - On release: next edge state=ARB, grant_o=0, ptr=(g+1) mod N.
  - Otherwise, if wr=1, burst count increments.
- Full handling:
  - While fifo_full_i=1 and req_valid_i[g]=1: no write, grant held, burst count held.
  - There is no timeout. Back-pressure propagates to producer g only.
- Latency and throughput:
  - First word is accepted 1 cycle after the valid is seen in ARB.
  - One-cycle ARB bubble between grants.
  - Peak rate is BURST words per BURST+1 cycles.
- Boundary cases:
  - Pointer wraps N-1 -> 0.
  - A requester dropping valid mid-burst forfeits the remaining burst.
  - Single active requester is re-granted after each bubble.
  - Requester g re-asserting in the same cycle as release waits its rotation turn.
- Invariants:
  - grant_o is at most one-hot.
  - fifo_wrreq_o=1 implies fifo_full_i=0.
  - Words from one grant enter the FIFO contiguously and in order.

Test Plan:
- Reset mid-burst: requester 1 granted, 2 words written, srst_i for 1 cycle -> next edge grant_o=0, busy_o=0, fifo_wrreq_o=0. After reset, with all 4 valid, first grant is requester 0 (ptr=0).
- Round-robin: all 4 valid continuously, data k*16+n, BURST=4, FIFO never full -> grant order 0,1,2,3,0. Exactly 4 writes per grant. One idle cycle between grants. 16 words in 20 cycles after the first grant.
- Full back-pressure: requester 2 alone, fifo_full_i=1 for 3 cycles after its 2nd word -> wrreq_o=0 and ready_o[2]=0 for those 3 cycles, grant_o=4'b0100 held. Words 3,4 written after full clears, then release.
- Early release: requester 0 sends 2 words then drops valid, requester 3 valid -> 2 writes, release, next grant requester 3 (ptr=1 scan skips 1,2).
- Wrap and single requester: only requester 3 valid with 10 words -> grants of 4,4,2 words, each separated by a 1-cycle ARB. ptr wraps to 0 after each release.
- Scoreboard: random valid on 4 requesters, random full at 30% -> FIFO write stream equals the per-requester streams interleaved in BURST-bounded contiguous chunks. No write while full. grant_o never multi-hot.
